// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM March C- BIST: FSM states, march table, result widths.
package sram_bist_pkg;

  localparam int unsigned FAIL_CNT_W = 16;
  localparam int unsigned ELEM_W     = 3;
  localparam logic [ELEM_W-1:0] LAST_ELEM = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } state_e;

  // One march element: direction, op count, and (read?, data value) per op.
  typedef struct packed {
    logic down;
    logic two_ops;
    logic op0_rd;
    logic op0_val;
    logic op1_rd;
    logic op1_val;
  } elem_cfg_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0); entries 6-7 unused.
  localparam elem_cfg_t MARCH_TBL [8] = '{
    6'b0_0_0_0_0_0,
    6'b0_1_1_0_0_1,
    6'b0_1_1_1_0_0,
    6'b1_1_1_0_0_1,
    6'b1_1_1_1_0_0,
    6'b0_0_1_0_0_0,
    6'b0_0_0_0_0_0,
    6'b0_0_0_0_0_0
  };

endpackage

// File: rtl/sram_bist_cmp_pipe.sv
// Read-compare pipeline: carries expected word/address/element alongside the macro read latency.
module sram_bist_cmp_pipe
  import sram_bist_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH   = 32,
  parameter int unsigned P_ADDR_WIDTH   = 8,
  parameter int unsigned P_READ_LATENCY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_vld,
  input  logic [P_DATA_WIDTH-1:0] i_exp,
  input  logic [P_ADDR_WIDTH-1:0] i_addr,
  input  logic [ELEM_W-1:0]       i_elem,
  input  logic [P_DATA_WIDTH-1:0] i_dout,
  output logic                    o_miscmp_c,
  output logic [P_ADDR_WIDTH-1:0] o_addr,
  output logic [ELEM_W-1:0]       o_elem
);

  localparam int unsigned LAST = P_READ_LATENCY - 1;

  logic [P_READ_LATENCY-1:0] r_vld;
  logic [P_DATA_WIDTH-1:0]   r_exp  [P_READ_LATENCY];
  logic [P_ADDR_WIDTH-1:0]   r_addr [P_READ_LATENCY];
  logic [ELEM_W-1:0]         r_elem [P_READ_LATENCY];

  // Stage 0 loads on the edge the macro captures the read; last stage meets valid read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < int'(P_READ_LATENCY); i++) begin
        r_exp[i]  <= '0;
        r_addr[i] <= '0;
        r_elem[i] <= '0;
      end
    end else begin
      r_vld[0]  <= i_vld && !i_flush;
      r_exp[0]  <= i_exp;
      r_addr[0] <= i_addr;
      r_elem[0] <= i_elem;
      for (int i = 1; i < int'(P_READ_LATENCY); i++) begin
        r_vld[i]  <= r_vld[i-1] && !i_flush;
        r_exp[i]  <= r_exp[i-1];
        r_addr[i] <= r_addr[i-1];
        r_elem[i] <= r_elem[i-1];
      end
    end
  end

  assign o_miscmp_c = r_vld[LAST] && (i_dout != r_exp[LAST]);
  assign o_addr     = r_addr[LAST];
  assign o_elem     = r_elem[LAST];

endmodule

// File: rtl/sram_bist_march.sv
// March C- memory BIST controller driving a macro BIST port, one operation per cycle.
module sram_bist_march
  import sram_bist_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH   = 32,
  parameter int unsigned P_ADDR_WIDTH   = 8,
  parameter int unsigned P_READ_LATENCY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic [P_ADDR_WIDTH-1:0] o_fail_addr,
  output logic [ELEM_W-1:0]       o_fail_elem,
  output logic [FAIL_CNT_W-1:0]   o_fail_cnt,
  output logic                    o_bist_en,
  output logic                    o_bist_men,
  output logic                    o_bist_wen,
  output logic                    o_bist_ren,
  output logic [P_ADDR_WIDTH-1:0] o_bist_addr,
  output logic [P_DATA_WIDTH-1:0] o_bist_din,
  output logic [P_DATA_WIDTH-1:0] o_bist_bm,
  input  logic [P_DATA_WIDTH-1:0] i_bist_dout
);

  localparam int unsigned DRAIN_W = (P_READ_LATENCY > 1) ? $clog2(P_READ_LATENCY) : 1;

  state_e                  r_state, w_state_nxt;
  logic [ELEM_W-1:0]       r_elem, w_elem_nxt, w_elem_inc;
  logic [P_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                    r_op, w_op_nxt;
  logic [DRAIN_W-1:0]      r_drain, w_drain_nxt;
  logic                    w_last_op, w_elem_end, w_run_nxt, w_rd_nxt, w_val_nxt;
  logic                    r_busy, r_done, r_bist_en, r_bist_wen, r_bist_ren, r_bist_val;
  logic                    r_pass;
  logic [P_ADDR_WIDTH-1:0] r_fail_addr;
  logic [ELEM_W-1:0]       r_fail_elem;
  logic [FAIL_CNT_W-1:0]   r_fail_cnt;
  logic                    w_start, w_abort, w_miscmp_c;
  logic [P_ADDR_WIDTH-1:0] w_cmp_addr;
  logic [ELEM_W-1:0]       w_cmp_elem;

  // r_elem/r_addr/r_op always describe the operation currently presented on the port.
  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_addr_nxt  = r_addr;
    w_op_nxt    = r_op;
    w_drain_nxt = r_drain;
    w_last_op   = !MARCH_TBL[r_elem].two_ops || r_op;
    w_elem_end  = w_last_op && (MARCH_TBL[r_elem].down ? (r_addr == '0) : (r_addr == '1));
    w_elem_inc  = r_elem + ELEM_W'(1);
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_elem_nxt  = '0;
          w_addr_nxt  = '0;
          w_op_nxt    = 1'b0;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
          w_elem_nxt  = '0;
          w_addr_nxt  = '0;
          w_op_nxt    = 1'b0;
        end else if (!w_last_op) begin
          w_op_nxt = 1'b1;
        end else if (!w_elem_end) begin
          w_op_nxt   = 1'b0;
          w_addr_nxt = MARCH_TBL[r_elem].down ? r_addr - P_ADDR_WIDTH'(1)
                                              : r_addr + P_ADDR_WIDTH'(1);
        end else if (r_elem == LAST_ELEM) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = '0;
          w_elem_nxt  = '0;
          w_addr_nxt  = '0;
          w_op_nxt    = 1'b0;
        end else begin
          w_elem_nxt = w_elem_inc;
          w_op_nxt   = 1'b0;
          w_addr_nxt = MARCH_TBL[w_elem_inc].down ? '1 : '0;
        end
      end
      ST_DRAIN: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_drain == DRAIN_W'(P_READ_LATENCY - 1)) begin
          w_state_nxt = ST_FINISH;
        end else begin
          w_drain_nxt = r_drain + DRAIN_W'(1);
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    w_run_nxt = (w_state_nxt == ST_RUN);
    w_rd_nxt  = w_run_nxt && (w_op_nxt ? MARCH_TBL[w_elem_nxt].op1_rd  : MARCH_TBL[w_elem_nxt].op0_rd);
    w_val_nxt = w_run_nxt && (w_op_nxt ? MARCH_TBL[w_elem_nxt].op1_val : MARCH_TBL[w_elem_nxt].op0_val);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_elem     <= '0;
      r_addr     <= '0;
      r_op       <= 1'b0;
      r_drain    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bist_en  <= 1'b0;
      r_bist_wen <= 1'b0;
      r_bist_ren <= 1'b0;
      r_bist_val <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_elem     <= w_elem_nxt;
      r_addr     <= w_addr_nxt;
      r_op       <= w_op_nxt;
      r_drain    <= w_drain_nxt;
      r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_done     <= (w_state_nxt == ST_FINISH);
      r_bist_en  <= w_run_nxt;
      r_bist_wen <= w_run_nxt && !w_rd_nxt;
      r_bist_ren <= w_rd_nxt;
      r_bist_val <= w_val_nxt;
    end
  end

  assign w_start = i_start && (r_state == ST_IDLE);
  assign w_abort = i_abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));

  sram_bist_cmp_pipe #(
    .P_DATA_WIDTH  (P_DATA_WIDTH),
    .P_ADDR_WIDTH  (P_ADDR_WIDTH),
    .P_READ_LATENCY(P_READ_LATENCY)
  ) u_cmp_pipe (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (w_abort),
    .i_vld     (r_bist_ren),
    .i_exp     ({P_DATA_WIDTH{r_bist_val}}),
    .i_addr    (r_addr),
    .i_elem    (r_elem),
    .i_dout    (i_bist_dout),
    .o_miscmp_c(w_miscmp_c),
    .o_addr    (w_cmp_addr),
    .o_elem    (w_cmp_elem)
  );

  // Abort beats a same-cycle compare; r_pass doubles as the "no miscompare yet" flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_cnt  <= '0;
    end else if (w_abort) begin
      r_pass <= 1'b0;
    end else if (w_start) begin
      r_pass      <= 1'b1;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_cnt  <= '0;
    end else if (w_miscmp_c) begin
      if (r_pass) begin
        r_fail_addr <= w_cmp_addr;
        r_fail_elem <= w_cmp_elem;
      end
      r_pass <= 1'b0;
      if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + FAIL_CNT_W'(1);
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_elem = r_fail_elem;
  assign o_fail_cnt  = r_fail_cnt;
  assign o_bist_en   = r_bist_en;
  assign o_bist_men  = r_bist_en;
  assign o_bist_wen  = r_bist_wen;
  assign o_bist_ren  = r_bist_ren;
  assign o_bist_addr = r_addr;
  assign o_bist_din  = {P_DATA_WIDTH{r_bist_val}};
  assign o_bist_bm   = {P_DATA_WIDTH{r_bist_en}};

endmodule

// File: tb/tb_sram_bist_march.sv
// Directed bench: default 256x32 / latency-1 instance and a 4x8 / latency-2 instance, each with a macro model.
module tb_sram_bist_march;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  // Instance A: defaults
  logic        a_start, a_abort, a_busy, a_done, a_pass;
  logic [7:0]  a_fail_addr;
  logic [2:0]  a_fail_elem;
  logic [15:0] a_fail_cnt;
  logic        a_en, a_men, a_wen, a_ren;
  logic [7:0]  a_addr;
  logic [31:0] a_din, a_bm, a_dout;
  logic [31:0] mem_a [256];
  logic        fault_a = 1'b0;
  int          a_ops = 0, a_dones = 0, a_viol = 0;

  // Instance B: 4 words x 8 bits, read latency 2
  logic        b_start, b_abort, b_busy, b_done, b_pass;
  logic [1:0]  b_fail_addr;
  logic [2:0]  b_fail_elem;
  logic [15:0] b_fail_cnt;
  logic        b_en, b_men, b_wen, b_ren;
  logic [1:0]  b_addr;
  logic [7:0]  b_din, b_bm, b_dout, qb0;
  logic [7:0]  mem_b [4];

  int b_a [40] = '{0,1,2,3, 0,0,1,1,2,2,3,3, 0,0,1,1,2,2,3,3,
                   3,3,2,2,1,1,0,0, 3,3,2,2,1,1,0,0, 0,1,2,3};
  int b_w [40] = '{1,1,1,1, 0,1,0,1,0,1,0,1, 0,1,0,1,0,1,0,1,
                   0,1,0,1,0,1,0,1, 0,1,0,1,0,1,0,1, 0,0,0,0};
  int b_v [40] = '{0,0,0,0, 0,1,0,1,0,1,0,1, 1,0,1,0,1,0,1,0,
                   0,1,0,1,0,1,0,1, 1,0,1,0,1,0,1,0, 0,0,0,0};

  sram_bist_march u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_abort(a_abort),
    .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
    .o_fail_addr(a_fail_addr), .o_fail_elem(a_fail_elem), .o_fail_cnt(a_fail_cnt),
    .o_bist_en(a_en), .o_bist_men(a_men), .o_bist_wen(a_wen), .o_bist_ren(a_ren),
    .o_bist_addr(a_addr), .o_bist_din(a_din), .o_bist_bm(a_bm), .i_bist_dout(a_dout)
  );

  sram_bist_march #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(2), .P_READ_LATENCY(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_abort(b_abort),
    .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_fail_addr(b_fail_addr), .o_fail_elem(b_fail_elem), .o_fail_cnt(b_fail_cnt),
    .o_bist_en(b_en), .o_bist_men(b_men), .o_bist_wen(b_wen), .o_bist_ren(b_ren),
    .o_bist_addr(b_addr), .o_bist_din(b_din), .o_bist_bm(b_bm), .i_bist_dout(b_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro A: read data valid after the capturing edge; optional bit-3 stuck-at-0 at 0x2A
  always @(posedge clk) begin
    if (a_en && a_men && a_wen) mem_a[a_addr] <= (mem_a[a_addr] & ~a_bm) | (a_din & a_bm);
    a_dout <= (fault_a && a_addr == 8'h2A) ? (mem_a[a_addr] & ~32'h8) : mem_a[a_addr];
  end

  // Macro B: one extra output register stage
  always @(posedge clk) begin
    if (b_en && b_men && b_wen) mem_b[b_addr] <= (mem_b[b_addr] & ~b_bm) | (b_din & b_bm);
    qb0    <= mem_b[b_addr];
    b_dout <= qb0;
  end

  always @(posedge clk) begin
    if (a_en) a_ops <= a_ops + 1;
    if (a_done) a_dones <= a_dones + 1;
  end

  always @(negedge clk) begin
    if (a_en && !(a_busy && a_men && (a_wen ^ a_ren) && a_bm == 32'hFFFF_FFFF &&
                  (a_din == 32'h0 || a_din == 32'hFFFF_FFFF)))
      a_viol <= a_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Leaves the caller at the negedge right after the START-sampling edge k.
  task automatic start_a();
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (a_done !== 1'b1 && cyc < 3000) begin
      step(1);
      cyc++;
    end
  endtask

  initial begin
    int cyc, base, d0;
    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0;
    b_start = 1'b0; b_abort = 1'b0;
    #12;
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_pass", 32'(a_pass), 32'd0);
    check("rst_en",   32'(a_en),   32'd0);
    check("rst_cnt",  32'(a_fail_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fault-free run at defaults
    start_a();
    base = a_ops;
    check("s1_busy0", 32'(a_busy), 32'd1);
    check("s1_op0",   32'({a_en, a_men, a_wen, a_ren, a_addr}), 32'({4'b1110, 8'h00}));
    check("s1_din0",  a_din, 32'h0);
    check("s1_bm0",   a_bm, 32'hFFFF_FFFF);
    check("s1_pass0", 32'(a_pass), 32'd1);
    wait_done_a(cyc);
    check("s1_done_lat", 32'(cyc), 32'd2561);
    check("s1_ops",   32'(a_ops - base), 32'd2560);
    check("s1_pass",  32'(a_pass), 32'd1);
    check("s1_cnt",   32'(a_fail_cnt), 32'd0);
    check("s1_busy",  32'(a_busy), 32'd0);
    check("s1_viol",  32'(a_viol), 32'd0);
    step(1);
    check("s1_done_pulse", 32'(a_done), 32'd0);
    check("s1_pass_sticky", 32'(a_pass), 32'd1);

    // ABORT while idle has no effect
    a_abort = 1'b1;
    step(1);
    a_abort = 1'b0;
    check("idle_abort_pass", 32'(a_pass), 32'd1);
    check("idle_abort_busy", 32'(a_busy), 32'd0);

    // Stuck-at-0 on bit 3 of word 0x2A
    fault_a = 1'b1;
    start_a();
    check("s2_pass0", 32'(a_pass), 32'd1);
    wait_done_a(cyc);
    check("s2_done_lat", 32'(cyc), 32'd2561);
    check("s2_pass",  32'(a_pass), 32'd0);
    check("s2_addr",  32'(a_fail_addr), 32'h2A);
    check("s2_elem",  32'(a_fail_elem), 32'd2);
    check("s2_cnt",   32'(a_fail_cnt), 32'd2);
    fault_a = 1'b0;

    // Abort at operation 100, then a complete rerun
    start_a();
    check("s3_clr_cnt",  32'(a_fail_cnt), 32'd0);
    check("s3_clr_addr", 32'(a_fail_addr), 32'd0);
    check("s3_clr_elem", 32'(a_fail_elem), 32'd0);
    check("s3_clr_pass", 32'(a_pass), 32'd1);
    d0 = a_dones;
    step(100);
    a_abort = 1'b1;
    step(1);
    a_abort = 1'b0;
    check("s3_ab_busy", 32'(a_busy), 32'd0);
    check("s3_ab_ctl",  32'({a_en, a_men, a_wen, a_ren}), 32'd0);
    check("s3_ab_pass", 32'(a_pass), 32'd0);
    check("s3_ab_done", 32'(a_done), 32'd0);
    step(2500);
    check("s3_no_done", 32'(a_dones - d0), 32'd0);
    start_a();
    wait_done_a(cyc);
    check("s3_rerun_lat",  32'(cyc), 32'd2561);
    check("s3_rerun_pass", 32'(a_pass), 32'd1);

    // START during BUSY ignored; async reset at operation 500
    start_a();
    base = a_ops;
    step(200);
    a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    step(299);
    check("s4_ops",  32'(a_ops - base), 32'd500);
    check("s4_op500", 32'({a_wen, a_ren, a_addr}), 32'({2'b01, 8'd122}));
    check("s4_busy", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s4_rst_stat", 32'({a_busy, a_done, a_pass}), 32'd0);
    check("s4_rst_fail", 32'({a_fail_addr, a_fail_elem, a_fail_cnt}), 32'd0);
    check("s4_rst_ctl",  32'({a_en, a_men, a_wen, a_ren, a_addr}), 32'd0);
    check("s4_rst_din",  a_din, 32'h0);
    check("s4_rst_bm",   a_bm, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    base = a_ops;
    step(20);
    check("s4_no_resume_busy", 32'(a_busy), 32'd0);
    check("s4_no_resume_ops",  32'(a_ops - base), 32'd0);

    // Small instance: per-op sequence, drain and completion latency
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step(1);
      check($sformatf("b_op%0d", i), 32'({b_en, b_wen, b_ren, b_addr, b_din}),
            32'((1 << 12) | (b_w[i] << 11) | ((1 - b_w[i]) << 10) | (b_a[i] << 8) |
                (b_v[i] != 0 ? 255 : 0)));
    end
    step(1);
    check("b_drain", 32'({b_busy, b_en}), 32'b10);
    cyc = 40;
    while (b_done !== 1'b1 && cyc < 200) begin
      step(1);
      cyc++;
    end
    check("b_done_lat", 32'(cyc), 32'd42);
    check("b_pass",     32'(b_pass), 32'd1);
    check("b_fail",     32'({b_fail_addr, b_fail_elem, b_fail_cnt}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
